trust_ack_tracker: RTL
======================

Name: trust_ack_tracker

Overview:
- Upstream feeder for the trust-based router's trust counters.
- Records every packet the router forwards as an outstanding entry (direction, packet id), then waits for that packet's acknowledgment.
- A matching ack produces a one-cycle trust-increment pulse for the direction.
- An entry with no ack within TIMEOUT cycles produces a one-cycle trust-decrement pulse.
- Pulses drive the router's per-direction trust update inputs. Direction encoding: 00 N, 01 S, 10 E, 11 W.

Parameters:
- ID_W, 4, packet id width.
- DEPTH, 4, number of outstanding-entry slots (>=2).
- TIMEOUT, 64, cycles an entry may wait for its ack before it is penalised (>=2).
- TMR_W, 8, per-slot timer width; TIMEOUT must be <= 2^TMR_W-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- send_valid  input  1  router forwarded a packet this cycle.
- send_ready  output  1  free slot available (combinational from registered occupancy).
- send_dir  input  2  direction the packet was forwarded to.
- send_id  input  ID_W  packet id.
- ack_valid  input  1  acknowledgment received this cycle.
- ack_dir  input  2  direction the ack refers to.
- ack_id  input  ID_W  acknowledged packet id.
- trust_inc  output  4  one-cycle increment pulses, bit order {N,S,E,W} ([3]=N … [0]=W).
- trust_dec  output  4  one-cycle decrement pulses, same bit order.
- ack_unmatched  output  1  one-cycle pulse: ack matched no entry.
- outstanding  output  $clog2(DEPTH+1)  number of valid slots.

Behaviour:
- Slot state: valid, dir[1:0], id[ID_W-1:0], timer[TMR_W-1:0].
- Reset (reset==0 at edge):
  - All slots invalid, timers 0.
  - trust_inc, trust_dec, ack_unmatched = 0; outstanding = 0; send_ready = 1.
  - Flushed entries generate no pulses. Reset mid-operation has identical effect.
- Allocation:
  - Accept when send_valid && send_ready.
  - Write the lowest-index invalid slot with valid=1, dir, id, timer=0.
  - send_valid while send_ready==0 is ignored (no state change, no pulse).
- Timer:
  - Every valid slot not freed this edge increments its timer, saturating at TIMEOUT.
  - A slot with timer==TIMEOUT is expired.
- Ack match:
  - On ack_valid, compare (ack_dir, ack_id) against all valid slots as registered before the edge, including expired slots.
  - Lowest-index hit is freed and trust_inc[dir] is registered high for exactly one cycle after the edge.
  - Duplicate outstanding (dir,id) pairs are retired one per ack, lowest index first.
  - No hit: ack_unmatched high for one cycle; no trust pulse.
- Timeout retire:
  - Per edge, the lowest-index expired slot not matched by an ack this cycle is freed and trust_dec[dir] is pulsed for one cycle.
  - Further expired slots wait, timer held at TIMEOUT.
  - At most one retire per cycle.
- Latency:
  - Send accepted at edge E: with no ack, trust_dec is high in the cycle following edge E+TIMEOUT+1, if no earlier-index expired slot is pending.
  - Ack at edge A: trust_inc is high in the cycle following edge A.
- Simultaneous events:
  - Ack hit and expiry on the same slot: ack wins (inc, no dec).
  - Ack and timeout on different slots in the same cycle: both are freed; trust_inc and trust_dec may be high together, including for the same direction.
  - Send and free in the same cycle: send_ready reflects pre-edge occupancy, so the freed slot is not reused until the next cycle.
  - An ack never matches a slot being allocated in the same cycle.
- outstanding:
  - Registered; updates by +1 (send), −1 per freed slot.
  - Never exceeds DEPTH, never underflows.
- Outputs:
  - trust_inc, trust_dec and ack_unmatched are registered and default to 0 each cycle.
  - Each pulse is exactly one cycle wide.

Test Plan:
- Reset → trust_inc=0, trust_dec=0, ack_unmatched=0, outstanding=0, send_ready=1; then hold reset=0 mid-traffic with 3 entries → outstanding=0 next cycle, no dec pulses ever issued for them.
- TIMEOUT=8: send dir=10 id=5, ack dir=10 id=5 three cycles later → trust_inc=4'b0010 for one cycle after the ack edge, outstanding 1→0, trust_dec stays 0.
- TIMEOUT=8: send dir=00 id=3 at edge 0, no ack → trust_dec=4'b1000 only in the cycle after edge 9; outstanding returns to 0.
- DEPTH=4: four sends → outstanding=4, send_ready=0; fifth send (dir=11 id=9) ignored; ack one entry → send_ready=1 the following cycle, outstanding=3.
- Ack dir=01 id=7 with empty table → ack_unmatched=1 for one cycle, trust_inc=0, outstanding=0.
- TIMEOUT=8: two sends dir=01 in the same setup (consecutive cycles), ack the second in the cycle it expires → trust_inc=4'b0100 for the second, trust_dec=4'b0100 once for the first. Separately, two slots expiring together → two trust_dec pulses in consecutive cycles.

Source files
------------

// File: rtl/trust_ack_tracker.sv
// Outstanding-packet table feeding the router's trust counters: a matched ack
// pulses trust_inc for the entry's direction, and an entry left unacked for TIMEOUT cycles pulses trust_dec.
module trust_ack_tracker #(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TMR_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         send_valid,
  output logic                         send_ready,
  input  logic [1:0]                   send_dir,
  input  logic [ID_W-1:0]              send_id,
  input  logic                         ack_valid,
  input  logic [1:0]                   ack_dir,
  input  logic [ID_W-1:0]              ack_id,
  output logic [3:0]                   trust_inc,
  output logic [3:0]                   trust_dec,
  output logic                         ack_unmatched,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [1:0]       dir_q   [DEPTH];
  logic [1:0]       dir_d   [DEPTH];
  logic [ID_W-1:0]  id_q    [DEPTH];
  logic [ID_W-1:0]  id_d    [DEPTH];
  logic [TMR_W-1:0] timer_q [DEPTH];
  logic [TMR_W-1:0] timer_d [DEPTH];

  logic [3:0]       inc_q, inc_d;
  logic [3:0]       dec_q, dec_d;
  logic             unm_q, unm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] alloc_sel, ack_sel, exp_sel;
  logic             alloc_found, ack_found, exp_found;
  logic             accept;

  // Direction code to {N,S,E,W} one-hot, N in bit 3.
  function automatic logic [3:0] dir_mask(input logic [1:0] d);
    return 4'b1000 >> d;
  endfunction

  assign send_ready    = ~&valid_q;
  assign accept        = send_valid & send_ready;
  assign trust_inc     = inc_q;
  assign trust_dec     = dec_q;
  assign ack_unmatched = unm_q;
  assign outstanding   = cnt_q;

  // Lowest-index priority picks, all against pre-edge slot state.
  always_comb begin
    alloc_sel   = '0;
    ack_sel     = '0;
    exp_sel     = '0;
    alloc_found = 1'b0;
    ack_found   = 1'b0;
    exp_found   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!alloc_found && !valid_q[i]) begin
        alloc_sel[i] = 1'b1;
        alloc_found  = 1'b1;
      end
      if (!ack_found && ack_valid && valid_q[i] &&
          dir_q[i] == ack_dir && id_q[i] == ack_id) begin
        ack_sel[i] = 1'b1;
        ack_found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!exp_found && valid_q[i] && timer_q[i] == TMO && !ack_sel[i]) begin
        exp_sel[i] = 1'b1;
        exp_found  = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    id_d    = id_q;
    timer_d = timer_q;
    inc_d   = '0;
    dec_d   = '0;
    unm_d   = ack_valid & ~ack_found;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ack_sel[i]) begin
        valid_d[i] = 1'b0;
        timer_d[i] = '0;
        inc_d      = dir_mask(dir_q[i]);
      end else if (exp_sel[i]) begin
        valid_d[i] = 1'b0;
        timer_d[i] = '0;
        dec_d      = dir_mask(dir_q[i]);
      end else if (valid_q[i]) begin
        if (timer_q[i] != TMO) timer_d[i] = timer_q[i] + TMR_W'(1);
      end else if (alloc_sel[i] && accept) begin
        valid_d[i] = 1'b1;
        dir_d[i]   = send_dir;
        id_d[i]    = send_id;
        timer_d[i] = '0;
      end
    end
    cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(ack_found) - CNT_W'(exp_found);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dir_q[i]   <= '0;
        id_q[i]    <= '0;
        timer_q[i] <= '0;
      end
      inc_q <= '0;
      dec_q <= '0;
      unm_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      timer_q <= timer_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      unm_q   <= unm_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
